pdm_sample_sequencer: RTL and testbench
=======================================

# pdm_sample_sequencer

Feeds the pulse-density modulator with audio samples at a fixed sample rate. Buffers producer samples in a small FIFO behind a valid/ready handshake, updates the modulator input once per sample period, and sequences pop-free start-up and shutdown by ramping the modulator input between 0 and midscale. It also owns the modulator's reset. Sits between the sample source (e.g. synthesizer/DMA) and the `pdm` datapath.

## Interface
- NBITS, 16, sample / modulator input width
- DIV, 256, clk cycles per sample period; >= 2
- DEPTH, 4, FIFO entries; power of two, >= 2
- RAMP_STEP, 64, ramp increment per sample period; 1..2^(NBITS-1)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_data  in  NBITS  producer sample, unsigned, midscale = silence
- s_valid  in  1  producer sample valid
- s_ready  out  1  FIFO can accept; push = s_valid && s_ready
- mute  in  1  level request: 1 = ramp down and idle, 0 = ramp up and play
- pdm_din  out  NBITS  modulator input, registered
- pdm_rst  out  1  modulator reset, registered
- sample_tick  out  1  one-cycle pulse coinciding with each new sample-period value on pdm_din
- underrun  out  1  one-cycle pulse: RUN tick found FIFO empty
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- active  out  1  state == RUN

## Operation
- MID = 2^(NBITS-1).
- Period counter `cnt` is free-running, 0..DIV-1, and wraps. Internal `tick` = (cnt == DIV-1). The counter runs in all states.
- State changes, pdm_din changes and FIFO pops happen only on tick cycles.
- States:
  - IDLE, on tick:
    - mute=0 -> RAMP_UP, pdm_rst<=0, pdm_din stays 0.
    - mute=1 -> stay.
  - RAMP_UP, on tick:
    - mute=1 -> RAMP_DOWN, pdm_din unchanged.
    - else pdm_din <= min(pdm_din+RAMP_STEP, MID); if the result == MID -> RUN.
  - RUN, on tick:
    - mute=1 -> RAMP_DOWN, no pop, pdm_din unchanged.
    - else if FIFO non-empty: pop the head into pdm_din.
    - else: pdm_din <= MID and pulse underrun.
  - RAMP_DOWN, on tick:
    - pdm_din <= max(pdm_din-RAMP_STEP, 0); if the result == 0 -> IDLE, pdm_rst<=1, FIFO flushed (level 0).
    - The ramp-down always completes; mute=0 is ignored until IDLE.
- Ramp arithmetic is computed in NBITS+1 bits and saturates, so there is no wrap-around.
- FIFO:
  - s_ready = !full && state != IDLE.
  - A push at full is impossible by construction.
  - Simultaneous push and pop: both take effect and level is unchanged.
  - A push into an empty FIFO on a RUN tick is not visible to that tick's pop: underrun pulses and the pushed sample is played next period.
  - Samples are played in push order. A sample is never dropped except by the flush on entry to IDLE.
- Reset mid-operation returns everything to reset values immediately; FIFO contents are discarded.

## Timing
- Reset values: pdm_din=0, pdm_rst=1, sample_tick=0, underrun=0, level=0, s_ready=0, active=0, state IDLE, cnt=0.
- The first tick is in the cycle with cnt==DIV-1, i.e. the DIV-th cycle after rst deasserts.
- pdm_din, pdm_rst, active and state update on the clk edge ending a tick cycle. sample_tick and underrun are high for exactly the following cycle, aligned with the new value. sample_tick pulses every period in every state, including IDLE.
- s_ready and level reflect registered FIFO state; a push becomes visible in level one cycle later.
- Start-up latency from mute=0 in IDLE to RUN: 1 + ceil(MID/RAMP_STEP) ticks.

## Test plan
- Reset and idle (NBITS=16, DIV=8, RAMP_STEP=0x4000, mute=1): pdm_rst=1, pdm_din=0 and s_ready=0 indefinitely; sample_tick pulses every 8 cycles starting 8 cycles after reset.
- Start-up (mute=0 from reset): pdm_din sequence across ticks is 0 (pdm_rst->0), 0x4000, 0x8000; active=1 after the third tick.
- Playback: push 0x1234, 0xABCD, 0x0001 in RUN; the next three ticks give pdm_din = 0x1234, 0xABCD, 0x0001; level returns to 0.
- Underrun and back-pressure: with no pushes in RUN, a tick gives pdm_din=0x8000 and one underrun pulse. Hold s_valid=1 without ticks: s_ready drops after DEPTH=4 accepts and level=4.
- Shutdown: mute=1 in RUN at pdm_din=0x9000: the next tick leaves din unchanged and enters RAMP_DOWN; following ticks give 0x5000, 0x1000, 0x0000; then pdm_rst=1, IDLE, level=0. A mute=0 glitch during RAMP_DOWN does not alter this sequence.
- Reset mid-RAMP_UP with FIFO holding 2 samples: the next cycle shows all reset values and level=0.

Source files
------------

// File: rtl/pdm_sample_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pdm_sample_sequencer
//  Description : Sample-rate pacer, FIFO and pop-free ramp sequencer for pdm.
//  Revision    : 1.0 - initial release
// ============================================================================
module pdm_sample_sequencer #(
    parameter int NBITS     = 16,
    parameter int DIV       = 256,
    parameter int DEPTH     = 4,
    parameter int RAMP_STEP = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NBITS-1:0]         s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     mute,
    output logic [NBITS-1:0]         pdm_din,
    output logic                     pdm_rst,
    output logic                     sample_tick,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     active
);

    localparam int                 c_cw      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int                 c_aw      = $clog2(DEPTH);
    localparam logic [c_cw-1:0]    c_cnt_max = c_cw'(DIV - 1);
    localparam logic [c_aw:0]      c_depth   = (c_aw + 1)'(DEPTH);
    localparam logic [NBITS:0]     c_mid     = {2'b01, {(NBITS - 1){1'b0}}};
    localparam logic [NBITS:0]     c_step    = (NBITS + 1)'(RAMP_STEP);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cw-1:0]    r_cnt;
    logic [NBITS-1:0]   r_din;
    logic [NBITS-1:0]   w_din_nxt;
    logic               r_pdm_rst;
    logic               w_pdm_rst_nxt;
    logic               r_tick_q;
    logic               r_underrun;
    logic               w_underrun_nxt;

    logic [NBITS-1:0]   r_mem [DEPTH];
    logic [c_aw-1:0]    r_wr_ptr;
    logic [c_aw-1:0]    r_rd_ptr;
    logic [c_aw:0]      r_level;

    logic               w_tick;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic               w_empty;
    logic               w_full;
    logic [NBITS:0]     w_up;
    logic [NBITS:0]     w_up_sat;
    logic [NBITS:0]     w_down_sat;

    assign w_tick  = (r_cnt == c_cnt_max);
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_depth);
    assign w_push  = s_valid && s_ready;

    // Ramp math carries one extra bit so saturation replaces wrap-around.
    assign w_up       = {1'b0, r_din} + c_step;
    assign w_up_sat   = (w_up >= c_mid) ? c_mid : w_up;
    assign w_down_sat = ({1'b0, r_din} > c_step) ? ({1'b0, r_din} - c_step) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cw'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_din      <= '0;
            r_pdm_rst  <= 1'b1;
            r_tick_q   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_din      <= w_din_nxt;
            r_pdm_rst  <= w_pdm_rst_nxt;
            r_tick_q   <= w_tick;
            r_underrun <= w_underrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_din_nxt      = r_din;
        w_pdm_rst_nxt  = r_pdm_rst;
        w_underrun_nxt = 1'b0;
        w_pop          = 1'b0;
        w_flush        = 1'b0;
        if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (!mute) begin
                        w_state_nxt   = ST_RAMP_UP;
                        w_pdm_rst_nxt = 1'b0;
                    end
                end
                ST_RAMP_UP: begin
                    if (mute) begin
                        w_state_nxt = ST_RAMP_DOWN;
                    end else begin
                        w_din_nxt = w_up_sat[NBITS-1:0];
                        if (w_up_sat == c_mid) begin
                            w_state_nxt = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (mute) begin
                        w_state_nxt = ST_RAMP_DOWN;
                    end else if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_din_nxt = r_mem[r_rd_ptr];
                    end else begin
                        w_din_nxt      = c_mid[NBITS-1:0];
                        w_underrun_nxt = 1'b1;
                    end
                end
                ST_RAMP_DOWN: begin
                    // mute is deliberately ignored: the ramp always reaches 0.
                    w_din_nxt = w_down_sat[NBITS-1:0];
                    if (w_down_sat == '0) begin
                        w_state_nxt   = ST_IDLE;
                        w_pdm_rst_nxt = 1'b1;
                        w_flush       = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Flush wins over a same-cycle push; the pop uses pre-edge occupancy.
    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + (c_aw + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - (c_aw + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    assign s_ready     = !w_full && (r_state != ST_IDLE);
    assign pdm_din     = r_din;
    assign pdm_rst     = r_pdm_rst;
    assign sample_tick = r_tick_q;
    assign underrun    = r_underrun;
    assign level       = r_level;
    assign active      = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_pdm_sample_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pdm_sample_sequencer
//  Description : Directed scenarios plus random run against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pdm_sample_sequencer;

    localparam int NBITS     = 16;
    localparam int DIV       = 8;
    localparam int DEPTH     = 4;
    localparam int RAMP_STEP = 'h4000;
    localparam int MID       = 'h8000;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic [15:0] s_data  = '0;
    logic        s_valid = 1'b0;
    logic        mute    = 1'b1;
    logic        s_ready;
    logic [15:0] pdm_din;
    logic        pdm_rst;
    logic        sample_tick;
    logic        underrun;
    logic [2:0]  level;
    logic        active;

    int n_checks = 0;
    int n_fail   = 0;

    pdm_sample_sequencer #(
        .NBITS    (NBITS),
        .DIV      (DIV),
        .DEPTH    (DEPTH),
        .RAMP_STEP(RAMP_STEP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .mute       (mute),
        .pdm_din    (pdm_din),
        .pdm_rst    (pdm_rst),
        .sample_tick(sample_tick),
        .underrun   (underrun),
        .level      (level),
        .active     (active)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 ramp up, 2 run, 3 ramp down.
    int          m_cnt = 0;
    int          m_mode = 0;
    int          m_din = 0;
    bit          m_rst = 1'b1;
    bit          m_tick = 1'b0;
    bit          m_und = 1'b0;
    logic [15:0] m_q [$];
    bit          m_tk, m_flush, m_push_ok;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_mode = 0; m_din = 0; m_rst = 1'b1;
            m_tick = 1'b0; m_und = 1'b0; m_q.delete();
        end else begin
            m_push_ok = s_valid && (m_mode != 0) && (m_q.size() < DEPTH);
            m_tk      = (m_cnt == DIV - 1);
            m_flush   = 1'b0;
            m_tick    = m_tk;
            m_und     = 1'b0;
            if (m_tk) begin
                case (m_mode)
                    0: if (!mute) begin m_mode = 1; m_rst = 1'b0; end
                    1: if (mute) m_mode = 3;
                       else begin
                           m_din = (m_din + RAMP_STEP > MID) ? MID : m_din + RAMP_STEP;
                           if (m_din == MID) m_mode = 2;
                       end
                    2: if (mute) m_mode = 3;
                       else if (m_q.size() > 0) m_din = int'(m_q.pop_front());
                       else begin m_din = MID; m_und = 1'b1; end
                    default: begin
                        m_din = (m_din > RAMP_STEP) ? m_din - RAMP_STEP : 0;
                        if (m_din == 0) begin m_mode = 0; m_rst = 1'b1; m_flush = 1'b1; end
                    end
                endcase
            end
            if (m_push_ok) m_q.push_back(s_data);
            if (m_flush) m_q.delete();
            m_cnt = (m_cnt + 1) % DIV;
        end
    end

    task automatic wait_tick(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 3 * DIV && !seen; i++) begin
            @(negedge clk);
            if (sample_tick) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: no sample_tick within %0d cycles", tag, 3 * DIV);
        end
    endtask

    task automatic do_reset(input bit mu);
        @(negedge clk);
        rst = 1'b1; mute = mu; s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; mute = 1'b1; s_valid = 1'b1; s_data = 16'($urandom);
        repeat (2) @(negedge clk);
        n_checks++;
        if (pdm_din !== 16'h0 || pdm_rst !== 1'b1 || sample_tick !== 1'b0 || underrun !== 1'b0 ||
            level !== 3'd0 || s_ready !== 1'b0 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: din=%h rst=%b tick=%b und=%b lvl=%0d rdy=%b act=%b, need 0000 1 0 0 0 0 0",
                     pdm_din, pdm_rst, sample_tick, underrun, level, s_ready, active);
        end
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            n_checks++;
            if (pdm_rst !== 1'b1 || pdm_din !== 16'h0 || s_ready !== 1'b0 || level !== 3'd0) begin
                n_fail++;
                $display("FAIL idle_hold cycle %0d: rst=%b din=%h rdy=%b lvl=%0d, need 1 0000 0 0",
                         k, pdm_rst, pdm_din, s_ready, level);
            end
            n_checks++;
            if (sample_tick !== ((k % DIV) == 0)) begin
                n_fail++;
                $display("FAIL idle_tick cycle %0d: sample_tick=%b need %b", k, sample_tick, (k % DIV) == 0);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_startup();
        logic [15:0] exp_din [3];
        exp_din[0] = 16'h0000; exp_din[1] = 16'h4000; exp_din[2] = 16'h8000;
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            wait_tick("startup");
            n_checks++;
            if (pdm_din !== exp_din[i] || pdm_rst !== 1'b0 || active !== (i == 2)) begin
                n_fail++;
                $display("FAIL startup tick %0d: din=%h rst=%b act=%b, need %h 0 %b",
                         i, pdm_din, pdm_rst, active, exp_din[i], i == 2);
            end
        end
    endtask

    task automatic test_playback();
        logic [15:0] vals [3];
        vals[0] = 16'h1234; vals[1] = 16'hABCD; vals[2] = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = vals[i];
            @(negedge clk);
        end
        s_valid = 1'b0;
        n_checks++;
        if (level !== 3'd3) begin
            n_fail++;
            $display("FAIL playback_level: level=%0d need 3", level);
        end
        for (int i = 0; i < 3; i++) begin
            wait_tick("playback");
            n_checks++;
            if (pdm_din !== vals[i] || underrun !== 1'b0) begin
                n_fail++;
                $display("FAIL playback sample %0d: din=%h und=%b need %h 0", i, pdm_din, underrun, vals[i]);
            end
        end
        n_checks++;
        if (level !== 3'd0) begin
            n_fail++;
            $display("FAIL playback_drain: level=%0d need 0", level);
        end
    endtask

    task automatic test_underrun_backpressure();
        logic [15:0] bp [4];
        wait_tick("underrun");
        n_checks++;
        if (pdm_din !== 16'h8000 || underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_tick: din=%h und=%b need 8000 1", pdm_din, underrun);
        end
        @(negedge clk);
        n_checks++;
        if (underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL underrun_width: und=%b need 0", underrun);
        end
        for (int i = 0; i < 3; i++) bp[i] = 16'($urandom);
        bp[3] = 16'h9000;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = bp[i];
            @(negedge clk);
        end
        n_checks++;
        if (s_ready !== 1'b0 || level !== 3'd4) begin
            n_fail++;
            $display("FAIL backpressure_full: rdy=%b lvl=%0d need 0 4", s_ready, level);
        end
        s_data = 16'hDEAD;
        @(negedge clk);
        s_valid = 1'b0;
        n_checks++;
        if (level !== 3'd4) begin
            n_fail++;
            $display("FAIL backpressure_hold: level=%0d need 4", level);
        end
        for (int i = 0; i < 4; i++) begin
            wait_tick("drain");
            n_checks++;
            if (pdm_din !== bp[i]) begin
                n_fail++;
                $display("FAIL drain_order %0d: din=%h need %h", i, pdm_din, bp[i]);
            end
        end
    endtask

    task automatic test_shutdown();
        logic [15:0] exp_din [3];
        exp_din[0] = 16'h5000; exp_din[1] = 16'h1000; exp_din[2] = 16'h0000;
        mute = 1'b1;
        wait_tick("shutdown_enter");
        n_checks++;
        if (pdm_din !== 16'h9000 || active !== 1'b0 || pdm_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL shutdown_enter: din=%h act=%b rst=%b need 9000 0 0", pdm_din, active, pdm_rst);
        end
        s_valid = 1'b1; s_data = 16'($urandom);
        @(negedge clk);
        s_valid = 1'b0;
        mute = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_tick("ramp_down");
            n_checks++;
            if (pdm_din !== exp_din[i] || pdm_rst !== (i == 2) || active !== 1'b0 ||
                level !== ((i == 2) ? 3'd0 : 3'd1)) begin
                n_fail++;
                $display("FAIL ramp_down %0d: din=%h rst=%b act=%b lvl=%0d need %h %b 0 %0d",
                         i, pdm_din, pdm_rst, active, level, exp_din[i], i == 2, (i == 2) ? 0 : 1);
            end
        end
        mute = 1'b1;
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_shutdown: s_ready=%b need 0", s_ready);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        wait_tick("mid_a");
        wait_tick("mid_b");
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_data = 16'($urandom);
            @(negedge clk);
        end
        s_valid = 1'b0;
        n_checks++;
        if (level !== 3'd2 || pdm_din !== 16'h4000) begin
            n_fail++;
            $display("FAIL mid_setup: lvl=%0d din=%h need 2 4000", level, pdm_din);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pdm_din !== 16'h0 || pdm_rst !== 1'b1 || sample_tick !== 1'b0 || underrun !== 1'b0 ||
            level !== 3'd0 || s_ready !== 1'b0 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: din=%h rst=%b tick=%b und=%b lvl=%0d rdy=%b act=%b, need 0000 1 0 0 0 0 0",
                     pdm_din, pdm_rst, sample_tick, underrun, level, s_ready, active);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        int thr [4];
        thr[0] = 2; thr[1] = 5; thr[2] = 1; thr[3] = 10;
        do_reset(1'($urandom_range(0, 1)));
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            n_checks++;
            if (pdm_din !== 16'(m_din) || pdm_rst !== m_rst || sample_tick !== m_tick ||
                underrun !== m_und || level !== 3'(m_q.size()) || active !== (m_mode == 2) ||
                s_ready !== ((m_mode != 0) && (m_q.size() < DEPTH))) begin
                n_fail++;
                $display("FAIL random cycle %0d: din=%h/%h rst=%b/%b tick=%b/%b und=%b/%b lvl=%0d/%0d act=%b/%b (dut/model)",
                         i, pdm_din, 16'(m_din), pdm_rst, m_rst, sample_tick, m_tick, underrun, m_und,
                         level, m_q.size(), active, m_mode == 2);
            end
            s_valid = ($urandom_range(0, 15) < thr[i / 1000]);
            s_data  = 16'($urandom);
            if ($urandom_range(0, 99) == 0) mute = ~mute;
            rst = ($urandom_range(0, 1499) == 0);
        end
        rst = 1'b0; s_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_playback();
        test_underrun_backpressure();
        test_shutdown();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
